// File: rtl/waveform_sequencer_if.sv
// Sample-source and SPI-DAC handshake bundle for waveform_sequencer.
// master = sequencer side, slave = word source / DAC master side.
interface waveform_sequencer_if #(
  parameter int unsigned WORD_WID = 20,
  parameter int unsigned DAC_WID  = 24
) ();
  logic [WORD_WID-1:0] word;
  logic                word_next;
  logic                word_ok;
  logic                word_last;
  logic                word_rst;
  logic [DAC_WID-1:0]  dac_out;
  logic                dac_arm;
  logic                dac_finished;

  modport master (
    input  word, word_ok, word_last, dac_finished,
    output word_next, word_rst, dac_out, dac_arm
  );

  modport slave (
    output word, word_ok, word_last, dac_finished,
    input  word_next, word_rst, dac_out, dac_arm
  );
endinterface

// File: rtl/waveform_sequencer.sv
// Waveform playback controller: fetches samples, applies a saturating signed offset,
// prefixes a DAC command and paces SPI frames at a programmed interval.
module waveform_sequencer #(
  parameter int unsigned DAC_WID = 24,
  parameter int unsigned WORD_WID = 20,
  parameter logic [DAC_WID-WORD_WID-1:0] DAC_CMD = 4'b0001,
  parameter int unsigned TIMER_WID = 32,
  parameter int unsigned LOOP_WID = 16,
  parameter int unsigned WORD_CNT_WID = 11
) (
  input  logic                    clk,
  input  logic                    rst_L,
  input  logic                    arm,
  input  logic [TIMER_WID-1:0]    time_to_wait,
  input  logic [LOOP_WID-1:0]     loop_count,
  input  logic signed [WORD_WID:0] offset,
  output logic                    running,
  output logic                    finished,
  output logic [LOOP_WID-1:0]     loops_done,
  output logic [WORD_CNT_WID-1:0] words_done,
  waveform_sequencer_if.master    bus
);

  typedef enum logic [2:0] {StIdle, StWait, StFetch, StSend, StDone} state_e;

  state_e                state_q;
  logic [TIMER_WID-1:0]  wait_q;
  logic [TIMER_WID-1:0]  timer_q;
  logic [LOOP_WID-1:0]   loop_lim_q;
  logic [WORD_WID:0]     offset_q;
  logic                  last_q;
  logic                  word_next_q;
  logic                  word_rst_q;
  logic                  dac_arm_q;
  logic [DAC_WID-1:0]    dac_out_q;

  logic [WORD_WID+1:0]   sum;
  logic [WORD_WID-1:0]   sat_word;
  logic [LOOP_WID-1:0]   loops_inc;

  // Sum is two bits wider than a sample: top bit is the sign, next bit flags overflow.
  always_comb begin
    sum = {2'b00, bus.word} + {offset_q[WORD_WID], offset_q};
    if (sum[WORD_WID+1]) begin
      sat_word = '0;
    end else if (sum[WORD_WID]) begin
      sat_word = '1;
    end else begin
      sat_word = sum[WORD_WID-1:0];
    end
  end

  assign loops_inc     = loops_done + 1'b1;
  assign running       = (state_q != StIdle);
  assign finished      = (state_q == StDone);
  assign bus.word_next = word_next_q;
  assign bus.word_rst  = word_rst_q;
  assign bus.dac_arm   = dac_arm_q;
  assign bus.dac_out   = dac_out_q;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      timer_q     <= '0;
      loop_lim_q  <= '0;
      offset_q    <= '0;
      last_q      <= 1'b0;
      word_next_q <= 1'b0;
      word_rst_q  <= 1'b1;
      dac_arm_q   <= 1'b0;
      dac_out_q   <= '0;
      loops_done  <= '0;
      words_done  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          word_rst_q <= 1'b1;
          if (arm) begin
            wait_q     <= time_to_wait;
            loop_lim_q <= loop_count;
            offset_q   <= offset;
            loops_done <= '0;
            words_done <= '0;
            timer_q    <= time_to_wait;
            word_rst_q <= 1'b0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (!arm) begin
            word_rst_q <= 1'b1;
            state_q    <= StIdle;
          end else begin
            word_rst_q <= 1'b0;
            if (timer_q == '0) begin
              word_next_q <= 1'b1;
              state_q     <= StFetch;
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
        end
        // Disarm is deliberately not sampled here so a requested word is always consumed.
        StFetch: begin
          if (bus.word_ok) begin
            word_next_q <= 1'b0;
            dac_out_q   <= {DAC_CMD, sat_word};
            dac_arm_q   <= 1'b1;
            last_q      <= bus.word_last;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (bus.dac_finished) begin
            dac_arm_q  <= 1'b0;
            words_done <= words_done + 1'b1;
            if (last_q) begin
              loops_done <= loops_inc;
            end
            if (last_q && (loop_lim_q != '0) && (loops_inc == loop_lim_q)) begin
              word_rst_q <= 1'b1;
              state_q    <= StDone;
            end else if (!arm) begin
              word_rst_q <= 1'b1;
              state_q    <= StIdle;
            end else begin
              // Rewind pulse lasts only the first WAIT cycle.
              word_rst_q <= last_q;
              timer_q    <= wait_q;
              state_q    <= StWait;
            end
          end
        end
        StDone: begin
          if (!arm) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_waveform_sequencer.sv
// Randomised bench for waveform_sequencer: a word-source and DAC responder drive the
// DUT while a behavioural model predicts every output on every cycle.
module tb_waveform_sequencer;

  logic                clk = 1'b0;
  logic                rst_L = 1'b0;
  logic                arm = 1'b0;
  logic [31:0]         time_to_wait = '0;
  logic [15:0]         loop_count = '0;
  logic signed [20:0]  offset = '0;
  logic                running;
  logic                finished;
  logic [15:0]         loops_done;
  logic [10:0]         words_done;

  waveform_sequencer_if #(.WORD_WID(20), .DAC_WID(24)) bus ();

  waveform_sequencer #(
    .DAC_WID(24), .WORD_WID(20), .DAC_CMD(4'b0001),
    .TIMER_WID(32), .LOOP_WID(16), .WORD_CNT_WID(11)
  ) dut (
    .clk(clk), .rst_L(rst_L), .arm(arm), .time_to_wait(time_to_wait),
    .loop_count(loop_count), .offset(offset), .running(running), .finished(finished),
    .loops_done(loops_done), .words_done(words_done), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_ref(input int w, input int o);
    int s;
    s = w + o;
    if (s < 0) return 0;
    if (s > 1048575) return 1048575;
    return s;
  endfunction

  // ---------------- word source responder ----------------
  logic [19:0] src_mem [8];
  int          src_len = 1;
  int          src_idx = 0;
  int          src_lat_max = 3;
  bit          src_stall = 0;

  initial begin
    int lat;
    bit pend;
    lat = 0;
    pend = 0;
    bus.word_ok = 1'b0;
    bus.word_last = 1'b0;
    bus.word = '0;
    forever begin
      @(negedge clk);
      if (bus.word_ok) begin
        bus.word_ok = 1'b0;
        bus.word_last = 1'b0;
        src_idx = (src_idx + 1) % src_len;
      end
      if (bus.word_rst) src_idx = 0;
      if (bus.word_next && !bus.word_ok && !src_stall) begin
        if (!pend) begin
          pend = 1;
          lat = $urandom_range(0, src_lat_max);
        end
        if (lat == 0) begin
          bus.word_ok = 1'b1;
          bus.word = src_mem[src_idx];
          bus.word_last = (src_idx == src_len - 1);
          pend = 0;
        end else begin
          lat--;
        end
      end else if (!bus.word_ok) begin
        if (!bus.word_next) pend = 0;
        // Stray word_last without word_ok must be ignored.
        bus.word = 20'($urandom);
        bus.word_last = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // ---------------- SPI DAC responder ----------------
  int spi_lat_max = 4;
  bit spi_stall = 0;

  initial begin
    int slat;
    bit spend;
    slat = 0;
    spend = 0;
    bus.dac_finished = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.dac_finished) begin
        bus.dac_finished = 1'b0;
      end else if (bus.dac_arm && !spi_stall) begin
        if (!spend) begin
          spend = 1;
          slat = $urandom_range(0, spi_lat_max);
        end
        if (slat == 0) begin
          bus.dac_finished = 1'b1;
          spend = 0;
        end else begin
          slat--;
        end
      end else if (!bus.dac_arm) begin
        spend = 0;
      end
    end
  end

  // ---------------- behavioural model ----------------
  bit          m_run, m_done, m_want, m_spi, m_last, m_rewind;
  longint      m_wait_left;
  logic [23:0] m_frame;
  int          m_words, m_loops;
  longint      lw;
  int          ll, lo;

  task automatic model_reset();
    m_run = 0; m_done = 0; m_want = 0; m_spi = 0; m_last = 0; m_rewind = 1;
    m_wait_left = -1; m_frame = '0; m_words = 0; m_loops = 0;
  endtask

  task automatic model_step();
    bit stop;
    if (!m_run) begin
      m_rewind = 1;
      if (arm) begin
        lw = longint'(time_to_wait); ll = int'(loop_count); lo = int'(offset);
        m_words = 0; m_loops = 0; m_wait_left = lw; m_rewind = 0; m_run = 1;
      end
    end else if (m_done) begin
      if (!arm) begin m_run = 0; m_done = 0; end
    end else if (m_wait_left >= 0) begin
      if (!arm) begin
        m_run = 0; m_wait_left = -1; m_rewind = 1;
      end else begin
        m_rewind = 0;
        if (m_wait_left == 0) begin m_want = 1; m_wait_left = -1; end
        else m_wait_left--;
      end
    end else if (m_want) begin
      if (bus.word_ok) begin
        m_want = 0; m_spi = 1; m_last = bus.word_last;
        m_frame = 24'h100000 | 24'(sat_ref(int'(bus.word), lo));
      end
    end else if (m_spi && bus.dac_finished) begin
      m_spi = 0;
      m_words = (m_words + 1) % 2048;
      stop = 0;
      if (m_last) begin
        m_loops = (m_loops + 1) % 65536;
        stop = (ll != 0) && (m_loops == ll);
      end
      if (stop) begin
        m_done = 1; m_rewind = 1;
      end else if (!arm) begin
        m_run = 0; m_rewind = 1;
      end else begin
        m_rewind = m_last; m_wait_left = lw;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_L);
      if (!rst_L) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare and event monitor ----------------
  int          cyc = 0;
  int          rise_q[$];
  logic [23:0] last_frame = '0;
  int          wrst_pulses = 0;
  int          wn_count = 0;

  initial begin
    logic p_arm, p_wrst, p_wn;
    p_arm = 0; p_wrst = 1; p_wn = 0;
    forever begin
      @(negedge clk);
      cyc++;
      check("running", running, m_run);
      check("finished", finished, m_done);
      check("word_next", bus.word_next, m_want);
      check("dac_arm", bus.dac_arm, m_spi);
      check("dac_out", bus.dac_out, m_frame);
      check("word_rst", bus.word_rst, m_rewind);
      check("words_done", words_done, 64'(m_words));
      check("loops_done", loops_done, 64'(m_loops));
      if (bus.dac_arm && !p_arm) begin rise_q.push_back(cyc); last_frame = bus.dac_out; end
      if (bus.word_rst && !p_wrst && running && !finished) wrst_pulses++;
      if (bus.word_next && !p_wn) wn_count++;
      p_arm = bus.dac_arm; p_wrst = bus.word_rst; p_wn = bus.word_next;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  task automatic start_run(input int w, input int lp, input logic signed [20:0] off);
    @(negedge clk);
    time_to_wait = 32'(w); loop_count = 16'(lp); offset = off; arm = 1'b1;
  endtask

  task automatic wait_fin(input int budget, input string name);
    int k;
    k = 0;
    while (finished !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    check(name, finished, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (running !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    check(name, running, 0);
  endtask

  task automatic end_run();
    @(negedge clk);
    arm = 1'b0;
    wait_idle(200, "end_idle");
  endtask

  initial begin
    int k, snap;
    repeat (3) @(negedge clk);
    check("rst_word_rst", bus.word_rst, 1);
    check("rst_running", running, 0);
    check("rst_dac_out", bus.dac_out, 0);
    check("rst_words", words_done, 0);
    check("sat_low_model", 64'(sat_ref(5, -10)), 0);
    check("sat_high_model", 64'(sat_ref(1048573, 10)), 64'hFFFFF);
    check("sat_pass_model", 64'(sat_ref(12345, 0)), 12345);
    rst_L = 1'b1;
    repeat (2) @(negedge clk);

    // wait=3, 4 words, one loop, zero handshake latency
    src_lat_max = 0; spi_lat_max = 0;
    src_len = 4;
    for (int i = 0; i < 4; i++) src_mem[i] = 20'($urandom);
    rise_q.delete();
    start_run(3, 1, 21'sd0);
    wait_fin(300, "d1_finish");
    check("d1_words", words_done, 4);
    check("d1_loops", loops_done, 1);
    check("d1_rises", rise_q.size(), 4);
    if (rise_q.size() == 4)
      for (int i = 1; i < 4; i++) check("d1_spacing", rise_q[i] - rise_q[i-1], 6);
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    check("d1_running_drop", running, 0);

    // saturation through the DUT
    src_len = 1; src_mem[0] = 20'd5;
    start_run(0, 1, -21'sd10);
    wait_fin(100, "sat_low_fin");
    check("sat_low_dut", last_frame, 24'h100000);
    end_run();
    src_mem[0] = 20'hFFFFD;
    start_run(0, 1, 21'sd10);
    wait_fin(100, "sat_high_fin");
    check("sat_high_dut", last_frame, 24'h1FFFFF);
    end_run();
    src_mem[0] = 20'h12345;
    start_run(1, 1, 21'sd0);
    wait_fin(100, "sat_pass_fin");
    check("sat_pass_dut", last_frame, 24'h112345);
    end_run();

    // three loops of a two-word source
    src_lat_max = 3; spi_lat_max = 4;
    src_len = 2; src_mem[0] = 20'h00AAA; src_mem[1] = 20'h00555;
    wrst_pulses = 0;
    start_run(2, 3, 21'sd7);
    wait_fin(400, "l3_finish");
    check("l3_rewinds", wrst_pulses, 2);
    check("l3_words", words_done, 6);
    check("l3_loops", loops_done, 3);
    end_run();

    // disarm while SPI frame is in flight
    spi_stall = 1;
    src_len = 3;
    start_run(1, 0, 21'sd0);
    k = 0;
    while (bus.dac_arm !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("ds_dac_arm_seen", bus.dac_arm, 1);
    arm = 1'b0;
    repeat (3) @(negedge clk);
    check("ds_dac_arm_held", bus.dac_arm, 1);
    check("ds_still_running", running, 1);
    spi_stall = 0;
    wait_idle(50, "ds_idle");
    check("ds_words", words_done, 1);
    snap = wn_count;
    repeat (10) @(negedge clk);
    check("ds_no_fetch", wn_count, snap);

    // disarm during a long wait
    snap = wn_count;
    start_run(100, 0, 21'sd0);
    repeat (10) @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    check("dw_idle_next", running, 0);
    repeat (5) @(negedge clk);
    check("dw_no_fetch", wn_count, snap);

    // asynchronous reset while fetching
    src_stall = 1;
    start_run(2, 1, 21'sd0);
    k = 0;
    while (bus.word_next !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    #1 rst_L = 1'b0;
    #1;
    check("ar_word_next", bus.word_next, 0);
    check("ar_word_rst", bus.word_rst, 1);
    check("ar_running", running, 0);
    check("ar_dac_arm", bus.dac_arm, 0);
    check("ar_words", words_done, 0);
    arm = 1'b0;
    src_stall = 0;
    @(negedge clk);
    rst_L = 1'b1;
    src_len = 3;
    start_run(1, 1, 21'sd3);
    wait_fin(200, "ar_rerun_fin");
    check("ar_rerun_words", words_done, 3);
    end_run();

    // randomized runs: random source, pacing, loops, offsets and disarm points
    for (int r = 0; r < 30; r++) begin
      int abort;
      src_len = $urandom_range(1, 5);
      for (int i = 0; i < src_len; i++)
        src_mem[i] = (r % 4 == 0) ? ((i % 2) ? 20'hFFFFF : 20'h0) : 20'($urandom);
      start_run($urandom_range(0, 5), $urandom_range(0, 3), 21'($urandom));
      abort = $urandom_range(10, 250);
      k = 0;
      while (finished !== 1'b1 && k < abort) begin
        @(negedge clk);
        k++;
        if (k == 3) begin
          time_to_wait = $urandom; loop_count = 16'($urandom); offset = 21'($urandom);
        end
      end
      arm = 1'b0;
      wait_idle(200, "rand_idle");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
